// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs LANES first-word-fall-through FIFO entries into one wide word
//
// Ports:
//   clk, n_rst          clock (rising edge) and asynchronous active-low reset
//   fifo_empty          FIFO empty flag
//   fifo_rdata          FIFO head entry, valid while fifo_empty=0
//   fifo_ren            pop request, combinational from state and fifo_empty
//   flush               single-cycle request to emit any partial word once the FIFO drains
//   out_valid/out_ready word handshake toward the bus-side consumer
//   out_data            packed word, lane 0 = oldest entry
//   out_keep            per-lane valid mask
//   out_last            word was produced by a flush
//   busy                packer holds state (word presented, lanes collected or flush pending)
module fifo_word_packer #(
  parameter int D_WIDTH = 8,
  parameter int LANES   = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       fifo_empty,
  input  logic [D_WIDTH-1:0]         fifo_rdata,
  output logic                       fifo_ren,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [D_WIDTH*LANES-1:0]   out_data,
  output logic [LANES-1:0]           out_keep,
  output logic                       out_last,
  output logic                       busy
);

  localparam int W     = D_WIDTH * LANES;
  localparam int CNT_W = $clog2(LANES + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pending_q, flush_pending_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     out_data_d;
  logic [LANES-1:0] out_keep_d;
  logic             out_valid_d, out_last_d;

  // Accumulator with the head entry dropped into lane cnt, and the partial
  // word / keep mask for a flush of the lanes collected so far.
  logic [W-1:0]     acc_pop;
  logic [W-1:0]     acc_partial;
  logic [LANES-1:0] keep_partial;

  always_comb begin
    acc_pop      = acc_q;
    acc_partial  = '0;
    keep_partial = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        acc_pop[i*D_WIDTH +: D_WIDTH] = fifo_rdata;
      end
      if (CNT_W'(i) < cnt_q) begin
        keep_partial[i]                   = 1'b1;
        acc_partial[i*D_WIDTH +: D_WIDTH] = acc_q[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    flush_pending_d = flush_pending_q | flush;
    acc_d           = acc_q;
    out_data_d      = out_data;
    out_keep_d      = out_keep;
    out_valid_d     = out_valid;
    out_last_d      = out_last;
    fifo_ren        = 1'b0;

    case (state_q)
      FILL: begin
        // Gated by n_rst so a preloaded FIFO is not drained while in reset.
        fifo_ren = n_rst & ~fifo_empty;
        if (!fifo_empty) begin
          acc_d = acc_pop;
          if (cnt_q == CNT_W'(LANES - 1)) begin
            state_d     = HOLD;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = acc_pop;
            out_keep_d  = '1;
            out_last_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (flush_pending_q) begin
          // Clearing wins over a flush arriving on the same edge.
          flush_pending_d = 1'b0;
          if (cnt_q != '0) begin
            state_d     = HOLD;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = acc_partial;
            out_keep_d  = keep_partial;
            out_last_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = FILL;
          out_valid_d = 1'b0;
          out_keep_d  = '0;
          out_last_d  = 1'b0;
          acc_d       = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= FILL;
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
      acc_q           <= '0;
      out_data        <= '0;
      out_keep        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
      acc_q           <= acc_d;
      out_data        <= out_data_d;
      out_keep        <= out_keep_d;
      out_valid       <= out_valid_d;
      out_last        <= out_last_d;
    end
  end

  assign busy = (state_q != FILL) | (cnt_q != '0) | flush_pending_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - directed self-checking bench for fifo_word_packer
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_ren;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        busy;

  int passed = 0;
  int total  = 0;

  // Behavioural first-word-fall-through FIFO feeding the DUT.
  logic [7:0] mem [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_ren && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  always #5 clk = ~clk;

  fifo_word_packer #(.D_WIDTH(8), .LANES(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_ren  (fifo_ren),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'h0);
    chk({tag, "_data"},  64'(out_data),  64'h0);
    chk({tag, "_keep"},  64'(out_keep),  64'h0);
    chk({tag, "_last"},  64'(out_last),  64'h0);
    chk({tag, "_busy"},  64'(busy),      64'h0);
  endtask

  initial begin
    n_rst     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    // FIFO preloaded while in reset: nothing may be popped yet.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    chk_idle("reset");
    chk("reset_ren", 64'(fifo_ren), 64'h0);
    tick();
    chk("reset_nopop", 64'(rd_ptr), 64'd0);

    // Test 1: full word, accepted immediately.
    n_rst = 1'b1;
    #1;
    chk("t1_ren_after_release", 64'(fifo_ren), 64'h1);
    @(negedge clk);
    tick(); tick();
    chk("t1_valid_edge3", 64'(out_valid), 64'h0);
    tick();
    chk("t1_valid", 64'(out_valid), 64'h1);
    chk("t1_data",  64'(out_data),  64'h44332211);
    chk("t1_keep",  64'(out_keep),  64'hf);
    chk("t1_last",  64'(out_last),  64'h0);
    chk("t1_busy",  64'(busy),      64'h1);
    tick();
    chk("t1_valid_drop", 64'(out_valid), 64'h0);
    chk("t1_keep_drop",  64'(out_keep),  64'h0);
    chk("t1_data_kept",  64'(out_data),  64'h44332211);
    chk("t1_busy_drop",  64'(busy),      64'h0);

    // Test 2: two words with a 5-cycle stall on the first.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(); tick(); tick(); tick();
    for (int s = 0; s < 5; s++) begin
      chk("t2_stall_valid", 64'(out_valid), 64'h1);
      chk("t2_stall_data",  64'(out_data),  64'h04030201);
      chk("t2_stall_ren",   64'(fifo_ren),  64'h0);
      if (s < 4) tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t2_accept_valid", 64'(out_valid), 64'h0);
    chk("t2_ren_resume",   64'(fifo_ren),  64'h1);
    tick(); tick(); tick(); tick();
    chk("t2_w2_valid", 64'(out_valid), 64'h1);
    chk("t2_w2_data",  64'(out_data),  64'h08070605);
    chk("t2_w2_keep",  64'(out_keep),  64'hf);
    tick();
    chk("t2_w2_gone", 64'(out_valid), 64'h0);
    chk("t2_popped",  64'(rd_ptr),    64'd12);

    // Test 3: partial word forced by flush.
    push(8'hAA); push(8'hBB);
    tick(); tick();
    chk("t3_partial_valid", 64'(out_valid), 64'h0);
    chk("t3_partial_busy",  64'(busy),      64'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_flush_latched", 64'(out_valid), 64'h0);
    tick();
    chk("t3_valid", 64'(out_valid), 64'h1);
    chk("t3_data",  64'(out_data),  64'h0000BBAA);
    chk("t3_keep",  64'(out_keep),  64'h3);
    chk("t3_last",  64'(out_last),  64'h1);
    tick();
    chk("t3_valid_drop", 64'(out_valid), 64'h0);
    chk("t3_last_drop",  64'(out_last),  64'h0);
    chk("t3_busy_drop",  64'(busy),      64'h0);

    // Test 4: flush with nothing collected produces no word.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_pending_busy", 64'(busy),      64'h1);
    chk("t4_valid0",       64'(out_valid), 64'h0);
    tick();
    chk("t4_cleared_busy", 64'(busy),      64'h0);
    chk("t4_valid1",       64'(out_valid), 64'h0);
    tick();
    chk("t4_valid2", 64'(out_valid), 64'h0);

    // Test 5: flush on the first pop, does not truncate the full word.
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick(); tick();
    chk("t5_w1_valid", 64'(out_valid), 64'h1);
    chk("t5_w1_data",  64'(out_data),  64'h13121110);
    chk("t5_w1_keep",  64'(out_keep),  64'hf);
    chk("t5_w1_last",  64'(out_last),  64'h0);
    tick();
    chk("t5_accept", 64'(out_valid), 64'h0);
    tick(); tick();
    chk("t5_filling", 64'(out_valid), 64'h0);
    tick();
    chk("t5_w2_valid", 64'(out_valid), 64'h1);
    chk("t5_w2_data",  64'(out_data),  64'h00001514);
    chk("t5_w2_keep",  64'(out_keep),  64'h3);
    chk("t5_w2_last",  64'(out_last),  64'h1);
    tick();
    chk("t5_done_busy", 64'(busy), 64'h0);

    // Test 6: reset in FILL with two lanes collected, then in HOLD.
    push(8'h21); push(8'h22);
    tick(); tick();
    chk("t6_busy_before", 64'(busy), 64'h1);
    n_rst = 1'b0;
    #1;
    chk_idle("t6_rst_fill");
    @(negedge clk);
    n_rst = 1'b1;
    out_ready = 1'b0;
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    tick(); tick(); tick(); tick();
    chk("t6_fresh_valid", 64'(out_valid), 64'h1);
    chk("t6_fresh_data",  64'(out_data),  64'h34333231);
    n_rst = 1'b0;
    #1;
    chk_idle("t6_rst_hold");
    @(negedge clk);
    n_rst = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    chk("t6_no_stale_valid", 64'(out_valid), 64'h0);
    chk("t6_no_stale_busy",  64'(busy),      64'h0);
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    tick(); tick(); tick(); tick();
    chk("t6_after_valid", 64'(out_valid), 64'h1);
    chk("t6_after_data",  64'(out_data),  64'h44434241);
    tick();
    chk("t6_after_drop", 64'(out_valid), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // fifo_ren must never assert against an empty FIFO.
  always @(negedge clk) begin
    if (fifo_ren && fifo_empty) begin
      total++;
      $error("FAIL ren_while_empty: observed=1 expected=0");
    end
  end

endmodule
